down_timer_8bit: RTL and testbench
==================================

// Module: down_timer_8bit
//
// PURPOSE
//   Loadable down-counter timer; the count-down counterpart of the 8-bit up counter.
//   Loads a reload value and decrements on each enabled clock. Raises a one-cycle tc
//   pulse on expiry.
//   Supports one-shot and auto-reload (periodic tick) modes, so it can act as a
//   prescaler or timeout source for downstream control FSMs.
//
// PARAMETERS
//   WIDTH    8   counter / reload value width in bits (>= 2)
//
// PORTS
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      load reload_val and start counting (sampled each clk)
//   stop         in   1      abort the count and return to IDLE; q is held
//   en           in   1      count enable; decrement only when 1
//   auto_reload  in   1      1 = periodic, 0 = one-shot; sampled on the expiry edge
//   reload_val   in   WIDTH  start/reload value, sampled on start and reload edges
//   q            out  WIDTH  current count (registered)
//   tc           out  1      terminal-count pulse, high exactly 1 cycle per expiry
//   busy         out  1      1 while in RUN
//   done         out  1      sticky one-shot completion flag
//
// BEHAVIOUR
//   - Reset (async): state=IDLE, q=0, tc=0, busy=0, done=0. Reset mid-count aborts
//     immediately, with no tc.
//   - FSM states: IDLE, RUN, DONE. All outputs are registered, and tc/q/done update on
//     the same edge.
//   - Priority on each edge: stop > start > expiry/decrement > hold.
//   - Effect of stop (any state): go to IDLE, q held, tc=0, done cleared, busy=0.
//   - Effect of start (any state, stop=0): q<=reload_val, go to RUN, busy=1, done=0,
//     tc=0.
//       * start while in RUN restarts the count, even on the would-be expiry cycle
//         (no tc).
//       * If reload_val==0 on start: q<=0, tc<=1 for one cycle, state=DONE, done=1,
//         busy=0. This applies even with auto_reload=1, so there is no zero-period
//         loop.
//   - RUN with en=0: q held, tc=0.
//   - RUN with en=1 and q>1: q<=q-1.
//   - RUN with en=1 and q==1 (expiry edge): tc<=1, then by mode:
//       * auto_reload=1: q<=reload_val and stay in RUN. The period is exactly
//         reload_val enabled cycles. If reload_val==0 here: q<=0, go to DONE, done=1.
//       * auto_reload=0: q<=0, go to DONE, busy<=0, done<=1.
//   - DONE: q=0. done stays 1 until the next start or stop. en is ignored.
//   - No wrap-around: q never decrements below 0.
//   - tc is deasserted on every edge that is not an expiry edge.
//   - Changes to reload_val in mid-count affect only the next load or reload.
//   - Latency: 1 clk from start to q=reload_val. A one-shot load of N with en=1 gives
//     tc exactly N clks after the load edge.
//
// TESTING (10 ns clock)
//   1. Reset, then hold reset=1 for 7 clks -> q=0, tc=0, busy=0, done=0 throughout.
//   2. One-shot: reload_val=5, auto_reload=0, en=1, 1-clk start pulse.
//      -> q counts 5,4,3,2,1,0; tc high only in the cycle q=0; done=1 and busy=0 after.
//   3. Auto-reload: reload_val=3, en=1, start.
//      -> q 3,2,1,3,2,1,...; tc every 3rd cycle, aligned with the reload; done stays 0.
//   4. en gating: reload_val=4, en toggles 1,0,1,0 -> q decrements only on en=1 cycles;
//      tc occurs 4 enabled cycles after the load.
//   5. Boundaries:
//      - start with reload_val=0 -> a single tc pulse, then DONE.
//      - start and stop in the same cycle -> IDLE, and q is unchanged.
//      - start on the q==1 cycle -> q=reload_val with no tc.
//   6. Async reset asserted mid-count (q=0x80) between clock edges.
//      -> q=0 and busy=0 immediately. No tc, and no count resumes after release.

Source files
------------

// File: rtl/down_timer_8bit.sv
// Loadable down-counter timer with one-shot and auto-reload modes.
// Emits a one-cycle tc pulse on expiry, plus a sticky done flag for one-shot completion.
module down_timer_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] reload_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (start) begin
      if (reload_val == '0) begin
        // Zero load expires at once and never enters RUN, even in auto-reload mode.
        count_d = '0;
        tc_d    = 1'b1;
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        count_d = reload_val;
        state_d = RUN;
        done_d  = 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              tc_d = 1'b1;
              if (auto_reload && (reload_val != '0)) begin
                count_d = reload_val;
              end else begin
                count_d = '0;
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
        end
        DONE: begin
          count_d = '0;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_down_timer_8bit.sv
// Scoreboard bench for down_timer_8bit: stimulus pushes model predictions, a monitor
// pops and compares them once per cycle on the falling edge.
module tb_down_timer_8bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       en;
  logic       auto_reload;
  logic [7:0] reload_val;
  logic [7:0] q;
  logic       tc;
  logic       busy;
  logic       done;

  down_timer_8bit #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .auto_reload(auto_reload),
    .reload_val (reload_val),
    .q          (q),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tc_seen = 0;
  logic stim_done = 1'b0;

  // Reference model: timer mode plus remaining count.
  typedef enum int { M_IDLE, M_RUN, M_DONE } mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_left = 0;
  bit     m_tc = 0;
  bit     m_done = 0;

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_left = 0;
    m_tc   = 0;
    m_done = 0;
  endfunction

  function automatic void model_step(bit st, bit sp, bit e, bit ar, int rv);
    m_tc = 0;
    if (sp) begin
      m_mode = M_IDLE;
      m_done = 0;
    end else if (st) begin
      m_left = rv;
      if (rv == 0) begin
        m_tc = 1; m_mode = M_DONE; m_done = 1;
      end else begin
        m_mode = M_RUN; m_done = 0;
      end
    end else if (m_mode == M_RUN && e) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_tc = 1;
        if (ar && rv != 0) m_left = rv;
        else begin m_mode = M_DONE; m_done = 1; end
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.q    = 8'(m_left);
    x.tc   = m_tc;
    x.busy = (m_mode == M_RUN);
    x.done = m_done;
    return x;
  endfunction

  task automatic cycle(bit st, bit sp, bit e, bit ar, int rv);
    start = st; stop = sp; en = e; auto_reload = ar; reload_val = 8'(rv);
    model_step(st, sp, e, ar, rv);
    sb.push_back(model_out());
    @(posedge clk); #1;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    start = 0; stop = 0; en = 0;
    model_reset();
    sb.push_back(model_out());
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (tc) tc_seen++;
        checks++;
        if (q !== e.q || tc !== e.tc || busy !== e.busy || done !== e.done) begin
          errors++;
          $display("FAIL outputs @%0t: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                   $time, q, tc, busy, done, e.q, e.tc, e.busy, e.done);
        end
      end
    end
  endtask

  task automatic stimulus();
    int t0;
    reset = 1'b1; start = 0; stop = 0; en = 0; auto_reload = 0; reload_val = 0;
    for (int i = 0; i < 7; i++) reset_cycle();
    reset = 1'b0;
    cycle(0, 0, 1, 0, 0);

    // One-shot of 5
    cycle(1, 0, 1, 0, 5);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 5);

    // Auto-reload period 3: three tc pulses over nine enabled cycles
    drain();
    t0 = tc_seen;
    cycle(1, 0, 1, 1, 3);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 1, 3);
    drain();
    checks++;
    if (tc_seen - t0 != 3) begin
      errors++;
      $display("FAIL autoreload_tc_count: got %0d pulses, required 3", tc_seen - t0);
    end
    cycle(0, 1, 1, 1, 3);

    // en gating
    cycle(1, 0, 1, 0, 4);
    for (int i = 0; i < 10; i++) cycle(0, 0, (i % 2) == 0, 0, 4);

    // Boundaries: zero load, start+stop together, restart on the q==1 cycle
    cycle(1, 0, 1, 1, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(1, 0, 1, 0, 6);
    cycle(0, 0, 1, 0, 6);
    cycle(1, 1, 1, 0, 9);
    cycle(0, 0, 1, 0, 9);
    cycle(1, 0, 1, 0, 2);
    cycle(0, 0, 1, 0, 2);
    cycle(1, 0, 1, 0, 7);
    cycle(0, 0, 1, 0, 7);
    cycle(0, 0, 1, 0, 7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int rv;
      rv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rv);
    end

    // Async reset mid-count at q=0x80
    cycle(1, 0, 1, 0, 8'h90);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 8'h90);
    drain();
    checks++;
    if (q !== 8'h80) begin
      errors++;
      $display("FAIL pre_reset_q: q=%0d, required %0d", q, 8'h80);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%0d busy=%b tc=%b, required q=0 busy=0 tc=0", q, busy, tc);
    end
    reset_cycle();
    reset_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 8'h90);
    drain();
    stim_done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL timeout: stimulus did not complete");
      end
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
